// File: rtl/parking_occupancy_ctrl.sv
// Parking occupancy front end: synchronises and debounces the entry/exit loop sensors,
// keeps the occupancy count and emits single-cycle accept/reject pulses for the door block.
module parking_occupancy_ctrl #(
    parameter int unsigned CAPACITY        = 20,
    parameter int unsigned CNT_W           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_raw,
    input  logic             exit_raw,
    output logic             entry_sensor,
    output logic             exit_sensor,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             entry_reject,
    output logic             exit_error
);

    typedef enum logic [1:0] {
        StIdle,
        StQual,
        StHeld,
        StRel
    } lane_state_e;

    localparam logic [DB_W-1:0]  DbLast = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DbOne  = DB_W'(1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // Lane 0 is the entry loop, lane 1 the exit loop.
    logic [1:0] raw;
    logic [1:0] meta_q;
    logic [1:0] sync_q;

    assign raw = {exit_raw, entry_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    lane_state_e     state_q [2];
    lane_state_e     state_d [2];
    logic [DB_W-1:0] dbc_q   [2];
    logic [DB_W-1:0] dbc_d   [2];
    logic [1:0]      qual;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            dbc_d[i]   = dbc_q[i];
            qual[i]    = 1'b0;
            unique case (state_q[i])
                StIdle: begin
                    dbc_d[i] = '0;
                    if (sync_q[i]) begin
                        state_d[i] = StQual;
                    end
                end
                StQual: begin
                    if (!sync_q[i]) begin
                        state_d[i] = StIdle;
                        dbc_d[i]   = '0;
                    end else if (dbc_q[i] == DbLast) begin
                        qual[i]    = 1'b1;
                        state_d[i] = StHeld;
                    end else begin
                        dbc_d[i] = dbc_q[i] + DbOne;
                    end
                end
                StHeld: begin
                    if (!sync_q[i]) begin
                        state_d[i] = StRel;
                        dbc_d[i]   = '0;
                    end
                end
                StRel: begin
                    // A short return of the vehicle signal is a glitch, not a new passage.
                    if (sync_q[i]) begin
                        state_d[i] = StHeld;
                    end else if (dbc_q[i] == DbLast) begin
                        state_d[i] = StIdle;
                    end else begin
                        dbc_d[i] = dbc_q[i] + DbOne;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    dbc_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StIdle;
                dbc_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                dbc_q[i]   <= dbc_d[i];
            end
        end
    end

    logic             exit_ok;
    logic             entry_ok;
    logic [CNT_W-1:0] count_d;

    // An exit in the same cycle frees a slot, so a full lot can still accept the entry.
    always_comb begin
        exit_ok  = qual[1] & (count != '0);
        entry_ok = qual[0] & ((count != CntMax) | exit_ok);
        count_d  = count;
        if (entry_ok && !exit_ok) begin
            count_d = count + CntOne;
        end else if (exit_ok && !entry_ok) begin
            count_d = count - CntOne;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_sensor <= 1'b0;
            exit_sensor  <= 1'b0;
            entry_reject <= 1'b0;
            exit_error   <= 1'b0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
        end else begin
            entry_sensor <= entry_ok;
            exit_sensor  <= exit_ok;
            entry_reject <= qual[0] & ~entry_ok;
            exit_error   <= qual[1] & ~exit_ok;
            count        <= count_d;
            full         <= (count_d == CntMax);
            empty        <= (count_d == '0);
        end
    end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scenario bench for parking_occupancy_ctrl: predicted pulse events are queued at stimulus time
// and matched (cycle, pulses, count, flags) by a monitor whenever the DUT emits a pulse.
module tb_parking_occupancy_ctrl;

    localparam int unsigned CAP = 3;
    localparam int unsigned CW  = 2;
    localparam int unsigned DC  = 4;
    localparam int unsigned DW  = 3;
    localparam int          LAT = DC + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          entry_raw = 1'b0;
    logic          exit_raw = 1'b0;
    logic          entry_sensor;
    logic          exit_sensor;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          entry_reject;
    logic          exit_error;

    parking_occupancy_ctrl #(
        .CAPACITY        (CAP),
        .CNT_W           (CW),
        .DEBOUNCE_CYCLES (DC),
        .DB_W            (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_raw    (entry_raw),
        .exit_raw     (exit_raw),
        .entry_sensor (entry_sensor),
        .exit_sensor  (exit_sensor),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .entry_reject (entry_reject),
        .exit_error   (exit_error)
    );

    always #5 clk = ~clk;

    // cyc holds the number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]   at;
        logic          e;
        logic          x;
        logic          rej;
        logic          err;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  model_count = 0;

    function automatic ev_t predict(input int at, input bit qe, input bit qx);
        ev_t ev;
        bit  xo;
        bit  eo;
        xo = qx && (model_count != 0);
        eo = qe && ((model_count != CAP) || xo);
        if (eo && !xo) model_count++;
        else if (xo && !eo) model_count--;
        ev.at    = 32'(at);
        ev.e     = eo;
        ev.x     = xo;
        ev.rej   = qe && !eo;
        ev.err   = qx && !xo;
        ev.cnt   = CW'(model_count);
        ev.full  = (model_count == CAP);
        ev.empty = (model_count == 0);
        return ev;
    endfunction

    ev_t act;
    ev_t exp_ev;
    always @(negedge clk) begin
        if (entry_sensor || exit_sensor || entry_reject || exit_error) begin
            act = '{at: 32'(cyc), e: entry_sensor, x: exit_sensor, rej: entry_reject,
                    err: exit_error, cnt: count, full: full, empty: empty};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got %h, required no pulse", act);
            end else begin
                exp_ev = exp_q.pop_front();
                if (act !== exp_ev)
                    $display("FAIL pulse_event: got %h, required %h", act, exp_ev);
                else
                    passes++;
            end
        end
    end

    // One passage on the selected lanes; both lanes rise on the same edge when both are set.
    task automatic vehicle(input bit e, input bit x, input int hi, input int lo);
        int k;
        @(negedge clk);
        entry_raw = e;
        exit_raw  = x;
        k = cyc + 1;
        exp_q.push_back(predict(k + LAT, e, x));
        repeat (hi) @(negedge clk);
        entry_raw = 1'b0;
        exit_raw  = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({count, full, empty, entry_sensor, exit_sensor, entry_reject, exit_error}
            !== {2'd0, 1'b0, 1'b1, 4'b0000})
            $display("FAIL reset_state: got cnt=%0d full=%b empty=%b pulses=%b, required 0/0/1/0000",
                     count, full, empty, {entry_sensor, exit_sensor, entry_reject, exit_error});
        else passes++;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({count, full, empty} !== {2'd0, 1'b0, 1'b1})
            $display("FAIL idle_after_reset: got cnt=%0d full=%b empty=%b, required 0/0/1",
                     count, full, empty);
        else passes++;
        entry_raw = 1'b1;
        repeat (2) @(negedge clk);
        entry_raw = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (count !== 2'd0) $display("FAIL glitch_count: got %0d, required 0", count);
        else passes++;
    endtask

    task automatic test_single_entry;
        vehicle(1'b1, 1'b0, 20, 12);
        checks++;
        if (exp_q.size() != 0) $display("FAIL single_entry_missing: got %0d pending, required 0",
                                        exp_q.size());
        else passes++;
        checks++;
        if ({count, empty, full} !== {2'd1, 1'b0, 1'b0})
            $display("FAIL single_entry_state: got cnt=%0d empty=%b full=%b, required 1/0/0",
                     count, empty, full);
        else passes++;
    endtask

    task automatic test_fill_and_reject;
        vehicle(1'b1, 1'b0, 8, 12);
        vehicle(1'b1, 1'b0, 8, 12);
        checks++;
        if ({count, full} !== {2'd3, 1'b1})
            $display("FAIL fill_state: got cnt=%0d full=%b, required 3/1", count, full);
        else passes++;
        vehicle(1'b1, 1'b0, 8, 12);
        checks++;
        if (exp_q.size() != 0 || count !== 2'd3)
            $display("FAIL reject_state: got pending=%0d cnt=%0d, required 0/3", exp_q.size(), count);
        else passes++;
    endtask

    task automatic test_simultaneous_full;
        vehicle(1'b1, 1'b1, 8, 12);
        checks++;
        if (exp_q.size() != 0 || {count, full} !== {2'd3, 1'b1})
            $display("FAIL simul_full: got pending=%0d cnt=%0d full=%b, required 0/3/1",
                     exp_q.size(), count, full);
        else passes++;
    endtask

    task automatic test_exit_error_glitch;
        int k;
        repeat (3) vehicle(1'b0, 1'b1, 8, 12);
        checks++;
        if ({count, empty} !== {2'd0, 1'b1})
            $display("FAIL drain_state: got cnt=%0d empty=%b, required 0/1", count, empty);
        else passes++;
        @(negedge clk);
        exit_raw = 1'b1;
        k = cyc + 1;
        exp_q.push_back(predict(k + LAT, 1'b0, 1'b1));
        repeat (8) @(negedge clk);
        exit_raw = 1'b0;
        repeat (2) @(negedge clk);
        exit_raw = 1'b1;
        repeat (8) @(negedge clk);
        exit_raw = 1'b0;
        repeat (14) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || {count, empty} !== {2'd0, 1'b1})
            $display("FAIL exit_error_state: got pending=%0d cnt=%0d empty=%b, required 0/0/1",
                     exp_q.size(), count, empty);
        else passes++;
    endtask

    task automatic test_simultaneous_empty;
        vehicle(1'b1, 1'b1, 8, 12);
        checks++;
        if (exp_q.size() != 0 || {count, empty} !== {2'd1, 1'b0})
            $display("FAIL simul_empty: got pending=%0d cnt=%0d empty=%b, required 0/1/0",
                     exp_q.size(), count, empty);
        else passes++;
    endtask

    task automatic test_reset_mid_qual;
        vehicle(1'b1, 1'b0, 8, 12);
        checks++;
        if (count !== 2'd2) $display("FAIL pre_reset_count: got %0d, required 2", count);
        else passes++;
        @(negedge clk);
        entry_raw = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_count = 0;
        #1;
        checks++;
        if ({count, full, empty, entry_sensor, exit_sensor, entry_reject, exit_error}
            !== {2'd0, 1'b0, 1'b1, 4'b0000})
            $display("FAIL mid_qual_reset: got cnt=%0d full=%b empty=%b pulses=%b, required 0/0/1/0000",
                     count, full, empty, {entry_sensor, exit_sensor, entry_reject, exit_error});
        else passes++;
        entry_raw = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || {count, empty} !== {2'd0, 1'b1})
            $display("FAIL post_reset_state: got pending=%0d cnt=%0d empty=%b, required 0/0/1",
                     exp_q.size(), count, empty);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_fill_and_reject();
        test_simultaneous_full();
        test_exit_error_glitch();
        test_simultaneous_empty();
        test_reset_mid_qual();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_ctrl.md
Name: parking_occupancy_ctrl

Overview:
Front-end stage that feeds the door flashing block. It synchronises and debounces the raw entry and exit loop-sensor inputs and turns each vehicle passage into a single-cycle event. It keeps the occupancy count and drives the entry_sensor, exit_sensor and full inputs of the door block. It also reports count, empty and rejected or illegal events to the display and status logic.

Parameters:
CAPACITY, 20, number of parking slots; full when count equals CAPACITY
CNT_W, 5, width of count; must satisfy 2^CNT_W > CAPACITY
DEBOUNCE_CYCLES, 500000, stable-level qualification time in clk cycles (10 ms at 50 MHz); minimum 2
DB_W, 20, width of debounce counter; must satisfy 2^DB_W >= DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
entry_raw  input  1  asynchronous raw entry loop sensor, high = vehicle present
exit_raw  input  1  asynchronous raw exit loop sensor, high = vehicle present
entry_sensor  output  1  one-cycle pulse, accepted entry; feeds the door block
exit_sensor  output  1  one-cycle pulse, accepted exit; feeds the door block
full  output  1  high when count == CAPACITY
empty  output  1  high when count == 0
count  output  CNT_W  current occupancy
entry_reject  output  1  one-cycle pulse, qualified entry refused because the lot is full
exit_error  output  1  one-cycle pulse, qualified exit while the lot is empty

Behaviour:
- Reset (reset low, asynchronous): all outputs are registered and clear to 0, except empty = 1. Synchronisers, both lane FSMs and the debounce counters also clear.
- Each raw input passes through a 2-flop synchroniser before any other logic; sync = the second flop.
- Each lane (entry and exit) has an identical FSM with its own debounce counter dbc:
  - IDLE: dbc = 0. When sync = 1, go to QUAL.
  - QUAL: if sync = 0, go to IDLE and clear dbc. Otherwise dbc increments. When dbc reaches DEBOUNCE_CYCLES-1, raise the lane's qualified strobe q (internal, one cycle) and go to HELD.
  - HELD: wait for sync = 0, then go to REL and clear dbc.
  - REL: if sync = 1, go back to HELD (glitch, no new event). Otherwise dbc increments. When dbc reaches DEBOUNCE_CYCLES-1, go to IDLE.
- Each vehicle produces at most one q per lane. A sensor held high indefinitely produces exactly one q.
- Latency: for a clean rising edge on raw first sampled at clock edge k, the corresponding output pulse is high during the cycle after edge k+DEBOUNCE_CYCLES+2. Each output pulse is exactly 1 cycle wide.
- Event acceptance, evaluated on the cycle q is high, using the current count:
  - exit_ok = qx & (count != 0)
  - entry_ok = qe & ((count != CAPACITY) | exit_ok)
  - entry_sensor <= entry_ok
  - entry_reject <= qe & ~entry_ok
  - exit_sensor <= exit_ok
  - exit_error <= qx & ~exit_ok
- Count update, on the same edge as the pulses:
  - +1 if entry_ok only; -1 if exit_ok only; unchanged if both or neither.
  - count never exceeds CAPACITY and never goes below 0; no wrap-around.
- full and empty are registered from the next count value, so they change on the same edge as count.
- Simultaneous entry and exit while full: both are accepted, count stays CAPACITY and full stays 1.
- Simultaneous entry and exit while empty: exit_error pulses, entry is accepted and count becomes 1.
- Reset asserted mid-qualification: the in-progress event is discarded, no pulse is produced, and count returns to 0.
- Glitches on the raw inputs shorter than DEBOUNCE_CYCLES produce no event in either direction.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES = 4, CAPACITY = 3.)
- Reset then idle: count = 0, empty = 1, full = 0, all pulses 0. A 2-cycle entry_raw glitch produces no pulse and count stays 0.
- entry_raw high for 20 cycles: exactly one entry_sensor pulse, 1 cycle wide, in the cycle after edge k+6. count = 1, empty = 0.
- Three clean entries: count = 3, full = 1. A fourth entry gives an entry_reject pulse, no entry_sensor pulse, and count stays 3.
- At count = 3, entry and exit qualify in the same cycle: entry_sensor and exit_sensor both pulse, count stays 3, full stays 1.
- At count = 0, an exit event gives an exit_error pulse, no exit_sensor pulse, and count stays 0. A release glitch (exit_raw low 2 cycles, then high, then low) during REL produces no second event.
- After count = 2, assert reset mid-QUAL on the entry lane: all outputs clear, count = 0, and no pulse appears after reset is released.
